// File: rtl/rv_enq_fifo.sv
// rv_enq_fifo: ready/valid FIFO with registered outputs and no bypass path,
// buffering producer items while the downstream consumer stalls.
module rv_enq_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic [WIDTH-1:0]         I_data,
    input  logic                     I_valid,
    output logic                     I_ready,
    output logic [WIDTH-1:0]         O_data,
    output logic                     O_valid,
    input  logic                     O_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [CW-1:0]    cnt;
    logic             enq, deq;
    // Handshake flags derive from registered state only, so no input-to-output paths exist.
    assign I_ready = cnt != CW'(DEPTH);
    assign O_valid = cnt != '0;
    assign O_data  = mem[rp];
    assign count   = cnt;
    assign enq     = I_valid && I_ready;
    assign deq     = O_valid && O_ready;
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (enq) begin
                mem[wp] <= I_data;
                wp      <= wp + AW'(1);
            end
            if (deq) rp <= rp + AW'(1);
            cnt <= cnt + CW'(enq) - CW'(deq);
        end
    end
endmodule

// File: tb/tb_rv_enq_fifo.sv
// tb_rv_enq_fifo: directed scenario tests for rv_enq_fifo with hand-computed expectations.
module tb_rv_enq_fifo;
    logic       CLK = 1'b0;
    logic       ASYNCRESETN = 1'b0;
    logic [4:0] I_data = '0;
    logic       I_valid = 1'b0;
    logic       I_ready;
    logic [4:0] O_data;
    logic       O_valid;
    logic       O_ready = 1'b0;
    logic [2:0] count;
    int total = 0;
    int bad = 0;

    rv_enq_fifo #(.WIDTH(5), .DEPTH(4)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .I_data(I_data), .I_valid(I_valid), .I_ready(I_ready),
        .O_data(O_data), .O_valid(O_valid), .O_ready(O_ready),
        .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        ASYNCRESETN = 1'b1;
        O_ready = 1'b0;
        I_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            I_data = 5'(i + 7);
            step();
        end
        I_valid = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL pre_reset_count got=%0d exp=3", count); end
        #2 ASYNCRESETN = 1'b0;
        #1;
        total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL rst_i_ready got=%b exp=1", I_ready); end
        total++; if (O_valid !== 1'b0) begin bad++; $display("FAIL rst_o_valid got=%b exp=0", O_valid); end
        total++; if (O_data !== 5'h00) begin bad++; $display("FAIL rst_o_data got=%h exp=00", O_data); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        step();
        ASYNCRESETN = 1'b1;
        I_valid = 1'b1;
        I_data = 5'h0A;
        step();
        I_valid = 1'b0;
        total++; if (O_valid !== 1'b1) begin bad++; $display("FAIL first_o_valid got=%b exp=1", O_valid); end
        total++; if (O_data !== 5'h0A) begin bad++; $display("FAIL first_o_data got=%h exp=0a", O_data); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL first_count got=%0d exp=1", count); end
        O_ready = 1'b1;
        step();
        O_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL first_drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_fill();
        O_ready = 1'b0;
        I_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            I_data = 5'(i);
            total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%b exp=1", i, I_ready); end
            step();
        end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
        total++; if (I_ready !== 1'b0) begin bad++; $display("FAIL full_i_ready got=%b exp=0", I_ready); end
        I_data = 5'h1F;
        step();
        step();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_reject_count got=%0d exp=4", count); end
        total++; if (O_data !== 5'd1) begin bad++; $display("FAIL full_head got=%h exp=01", O_data); end
        I_valid = 1'b0;
    endtask

    task automatic test_drain();
        O_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++; if (O_data !== 5'(i) || O_valid !== 1'b1) begin bad++; $display("FAIL drain_%0d got=%h/%b exp=%h/1", i, O_data, O_valid, 5'(i)); end
            step();
            if (i == 1) begin
                total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL drain_ready_rise got=%b exp=1", I_ready); end
            end
        end
        total++; if (O_valid !== 1'b0) begin bad++; $display("FAIL drain_o_valid got=%b exp=0", O_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
        O_ready = 1'b0;
    endtask

    task automatic test_full_deq();
        O_ready = 1'b0;
        I_valid = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            I_data = 5'(i);
            step();
        end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fd_prefill got=%0d exp=4", count); end
        O_ready = 1'b1;
        I_data = 5'd9;
        step();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL fd_deq_only got=%0d exp=3", count); end
        total++; if (O_data !== 5'd6) begin bad++; $display("FAIL fd_head got=%h exp=06", O_data); end
        step();
        I_valid = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL fd_both got=%0d exp=3", count); end
        for (int i = 7; i <= 9; i++) begin
            total++; if (O_data !== 5'(i)) begin bad++; $display("FAIL fd_order_%0d got=%h exp=%h", i, O_data, 5'(i)); end
            step();
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL fd_empty got=%0d exp=0", count); end
        O_ready = 1'b0;
    endtask

    task automatic test_stream();
        O_ready = 1'b0;
        I_valid = 1'b1;
        I_data = 5'd0;
        step();
        O_ready = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            I_data = 5'(i);
            total++; if (O_data !== 5'(i - 1) || count !== 3'd1 || O_valid !== 1'b1) begin bad++; $display("FAIL stream_%0d got=%h/%0d exp=%h/1", i, O_data, count, 5'(i - 1)); end
            step();
        end
        I_valid = 1'b0;
        total++; if (O_data !== 5'd19) begin bad++; $display("FAIL stream_last got=%h exp=13", O_data); end
        step();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL stream_empty got=%0d exp=0", count); end
        O_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [4:0] q[$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bool_loop: while (got < 10 && cyc < 200) begin
            logic exp_ready, exp_valid, e, d;
            O_ready = cyc[0] ? 1'b0 : 1'b1;
            I_valid = sent < 10;
            I_data = 5'(sent * 3 + 2);
            exp_ready = q.size() != 4;
            exp_valid = q.size() != 0;
            total++; if (I_ready !== exp_ready || O_valid !== exp_valid || count !== 3'(q.size())) begin bad++; $display("FAIL stall_flags_c%0d got=%b%b/%0d exp=%b%b/%0d", cyc, I_ready, O_valid, count, exp_ready, exp_valid, q.size()); end
            if (exp_valid) begin
                total++; if (O_data !== q[0]) begin bad++; $display("FAIL stall_data_c%0d got=%h exp=%h", cyc, O_data, q[0]); end
            end
            e = I_valid && exp_ready;
            d = exp_valid && O_ready;
            step();
            if (d) begin void'(q.pop_front()); got++; end
            if (e) begin q.push_back(5'(sent * 3 + 2)); sent++; end
            cyc++;
        end
        total++; if (got !== 10) begin bad++; $display("FAIL stall_delivered got=%0d exp=10", got); end
        I_valid = 1'b0;
        O_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_deq();
        test_stream();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
